sw_traceback: RTL

- Consumer end of the PE systolic array's pointer interface.
- Captures the per-PE `direction` pointers, tagged with their row ids, into an internal pointer matrix while the array streams.
- On a start request carrying the array's final max_h/maxRowId/maxColId, it walks the matrix back from the max cell.
- Emits one alignment operation per cell on a valid/ready stream, then pulses done with the path length.

---
 rtl/sw_traceback.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sw_traceback.sv
// rtl/sw_traceback.sv - Pointer-matrix capture and max-cell traceback walker emitting alignment ops
module sw_traceback #(
    parameter int N_COLS   = 5,
    parameter int MAX_ROWS = 16,
    parameter int ID_W     = 4,
    parameter int LEN_W    = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_COLS-1:0]              ptr_valid_i,
    input  logic [N_COLS-1:0][1:0]         ptr_in_i,
    input  logic [N_COLS-1:0][ID_W-1:0]    ptr_row_i,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic signed [15:0]             max_h_i,
    input  logic [ID_W-1:0]                max_row_i,
    input  logic [ID_W-1:0]                max_col_i,
    output logic                           busy_o,
    output logic                           op_valid_o,
    input  logic                           op_ready_i,
    output logic [1:0]                     op_o,
    output logic [ID_W-1:0]                op_row_o,
    output logic [ID_W-1:0]                op_col_o,
    output logic                           done_o,
    output logic [LEN_W-1:0]               path_len_o
);

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_DIAG = 2'd1;
    localparam logic [1:0] DIR_UP   = 2'd2;
    localparam logic [1:0] DIR_LEFT = 2'd3;

    // Longest possible walk: every step lowers row+col by at least one
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_ROWS + N_COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      mem_q [MAX_ROWS][N_COLS];
    logic [1:0]      op_q;
    logic [ID_W-1:0] cur_row_q, cur_col_q;
    logic [LEN_W-1:0] len_q;

    logic            row_ok, col_ok, start_go;
    logic [1:0]      start_cell;
    logic            hs, step_r, step_c, under;
    logic [ID_W-1:0] nxt_row, nxt_col;
    logic [1:0]      nxt_cell;

    function automatic logic in_rows(input logic [ID_W-1:0] r);
        return {{(32-ID_W){1'b0}}, r} < 32'(MAX_ROWS);
    endfunction

    function automatic logic in_cols(input logic [ID_W-1:0] c);
        return {{(32-ID_W){1'b0}}, c} < 32'(N_COLS);
    endfunction

    // Start qualification and successor-cell lookup for the walk
    always_comb begin
        row_ok     = in_rows(max_row_i);
        col_ok     = in_cols(max_col_i);
        start_cell = DIR_NONE;
        if (row_ok && col_ok) begin
            start_cell = mem_q[max_row_i][max_col_i];
        end
        start_go = (max_h_i > 16'sd0) && (start_cell != DIR_NONE);

        hs      = (state_q == S_WALK) && op_ready_i;
        step_r  = (op_q == DIR_DIAG) || (op_q == DIR_UP);
        step_c  = (op_q == DIR_DIAG) || (op_q == DIR_LEFT);
        under   = (step_r && (cur_row_q == '0)) || (step_c && (cur_col_q == '0));
        nxt_row = cur_row_q - {{(ID_W-1){1'b0}}, step_r};
        nxt_col = cur_col_q - {{(ID_W-1){1'b0}}, step_c};
        nxt_cell = DIR_NONE;
        if (!under) begin
            nxt_cell = mem_q[nxt_row][nxt_col];
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: an empty or invalid start goes straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = start_go ? S_WALK : S_DONE;
            S_WALK: if (hs && (under || (nxt_cell == DIR_NONE))) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy_o     = (state_q == S_WALK);
        op_valid_o = (state_q == S_WALK);
        done_o     = (state_q == S_DONE);
        op_o       = op_q;
        op_row_o   = cur_row_q;
        op_col_o   = cur_col_q;
        path_len_o = len_q;
    end

    // Walk datapath: latch the max cell on start, advance on each handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= DIR_NONE;
            cur_row_q <= '0;
            cur_col_q <= '0;
            len_q     <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            op_q      <= start_cell;
            cur_row_q <= max_row_i;
            cur_col_q <= max_col_i;
            len_q     <= '0;
        end else if (hs) begin
            if (len_q < LEN_MAX) begin
                len_q <= len_q + 1'b1;
            end
            if (!under) begin
                op_q      <= nxt_cell;
                cur_row_q <= nxt_row;
                cur_col_q <= nxt_col;
            end
        end
    end

    // Pointer matrix: capture only while idle, clear wins over writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < MAX_ROWS; r++) begin
                for (int c = 0; c < N_COLS; c++) begin
                    mem_q[r][c] <= DIR_NONE;
                end
            end
        end else if (state_q == S_IDLE) begin
            if (clear_i) begin
                for (int r = 0; r < MAX_ROWS; r++) begin
                    for (int c = 0; c < N_COLS; c++) begin
                        mem_q[r][c] <= DIR_NONE;
                    end
                end
            end else begin
                for (int i = 0; i < N_COLS; i++) begin
                    if (ptr_valid_i[i] && in_rows(ptr_row_i[i])) begin
                        mem_q[ptr_row_i[i]][i] <= ptr_in_i[i];
                    end
                end
            end
        end
    end

endmodule
